// File: rtl/cmd_frame_pkg.sv
// Shared types and helpers for the host command frame decoder.
// Frame layout: SYNC, A1, A0, D3, D2, D1, D0, CS (big-endian payload).
package cmd_frame_pkg;

  localparam logic [3:0] ST_HUNT = 4'd0;
  localparam logic [3:0] ST_A1   = 4'd1;
  localparam logic [3:0] ST_A0   = 4'd2;
  localparam logic [3:0] ST_D3   = 4'd3;
  localparam logic [3:0] ST_D2   = 4'd4;
  localparam logic [3:0] ST_D1   = 4'd5;
  localparam logic [3:0] ST_D0   = 4'd6;
  localparam logic [3:0] ST_CS   = 4'd7;
  localparam logic [3:0] ST_EMIT = 4'd8;

  typedef enum logic [3:0] {
    HUNT = ST_HUNT,
    A1   = ST_A1,
    A0   = ST_A0,
    D3   = ST_D3,
    D2   = ST_D2,
    D1   = ST_D1,
    D0   = ST_D0,
    CS   = ST_CS,
    EMIT = ST_EMIT
  } state_t;

  localparam int FRAME_PAYLOAD_BYTES = 6;
  localparam int PAYLOAD_WIDTH       = 8 * FRAME_PAYLOAD_BYTES;
  localparam int TIMER_WIDTH         = 20;

  // Running modulo-256 sum; a good frame sums to zero including the CS byte.
  function automatic logic [7:0] csum8(input logic [7:0] sum, input logic [7:0] data_byte);
    return sum + data_byte;
  endfunction

  // Successor of a payload-collecting state once its byte has been accepted.
  function automatic state_t payload_next(input state_t s);
    state_t n;
    case (s)
      A1:      n = A0;
      A0:      n = D3;
      D3:      n = D2;
      D2:      n = D1;
      D1:      n = D0;
      D0:      n = CS;
      default: n = HUNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cmd_frame_decoder_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping; clears only on reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_r;

  // Count events until all-ones is reached.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= '0;
    end else if (inc_i && (count_r != '1)) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/cmd_frame_decoder.sv
// Byte-stream frame decoder producing single-cycle register-write commands,
// with checksum and inter-byte timeout protection and saturating error counters.
module cmd_frame_decoder
  import cmd_frame_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               byte_i,
  input  logic                     byte_valid_i,
  output logic                     byte_ready_o,
  output logic [ADDR_WIDTH-1:0]    cmd_addr_o,
  output logic [DATA_WIDTH-1:0]    cmd_data_o,
  output logic                     cmd_valid_o,
  output logic [ERR_CNT_WIDTH-1:0] csum_err_cnt_o,
  output logic [ERR_CNT_WIDTH-1:0] timeout_cnt_o,
  output logic                     busy_o
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);

  state_t                     state_r, state_next_s;
  logic [TIMER_WIDTH-1:0]     timer_r, timer_next_s;
  logic [PAYLOAD_WIDTH-1:0]   payload_r, payload_next_s;
  logic [7:0]                 sum_r, sum_next_s;
  logic                       ready_r, busy_r, valid_r;
  logic [ADDR_WIDTH-1:0]      addr_r;
  logic [DATA_WIDTH-1:0]      data_r;
  logic                       accept_s, csum_err_s, timeout_s;
  logic [15:0]                addr16_s;
  logic [31:0]                data32_s;

  assign accept_s = byte_valid_i && ready_r;
  assign addr16_s = payload_r[PAYLOAD_WIDTH-1 -: 16];
  assign data32_s = payload_r[31:0];

  // Next-state, payload shift, checksum accumulation and inter-byte timer.
  always_comb begin
    state_next_s   = state_r;
    timer_next_s   = timer_r;
    payload_next_s = payload_r;
    sum_next_s     = sum_r;
    csum_err_s     = 1'b0;
    timeout_s      = 1'b0;
    case (state_r)
      HUNT: begin
        timer_next_s = '0;
        if (accept_s && (byte_i == SYNC_BYTE)) begin
          state_next_s = A1;
          sum_next_s   = 8'h00;
        end else begin
          state_next_s = HUNT;
        end
      end
      A1, A0, D3, D2, D1, D0: begin
        if (accept_s) begin
          state_next_s   = payload_next(state_r);
          payload_next_s = {payload_r[PAYLOAD_WIDTH-9:0], byte_i};
          sum_next_s     = csum8(sum_r, byte_i);
          timer_next_s   = '0;
        end else if (timer_r == TIMER_LAST) begin
          state_next_s = HUNT;
          timeout_s    = 1'b1;
          timer_next_s = '0;
        end else begin
          timer_next_s = timer_r + TIMER_ONE;
        end
      end
      CS: begin
        if (accept_s) begin
          timer_next_s = '0;
          if (csum8(sum_r, byte_i) == 8'h00) begin
            state_next_s = EMIT;
          end else begin
            state_next_s = HUNT;
            csum_err_s   = 1'b1;
          end
        end else if (timer_r == TIMER_LAST) begin
          state_next_s = HUNT;
          timeout_s    = 1'b1;
          timer_next_s = '0;
        end else begin
          timer_next_s = timer_r + TIMER_ONE;
        end
      end
      EMIT: begin
        state_next_s = HUNT;
        timer_next_s = '0;
      end
      default: begin
        state_next_s = HUNT;
        timer_next_s = '0;
      end
    endcase
  end

  // Frame state, timer and payload registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= HUNT;
      timer_r   <= '0;
      payload_r <= '0;
      sum_r     <= 8'h00;
    end else begin
      state_r   <= state_next_s;
      timer_r   <= timer_next_s;
      payload_r <= payload_next_s;
      sum_r     <= sum_next_s;
    end
  end

  // Registered handshake/status outputs; command fields load only on entry to EMIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
    end else begin
      ready_r <= (state_next_s != EMIT);
      busy_r  <= (state_next_s != HUNT);
      valid_r <= (state_next_s == EMIT);
      if (state_next_s == EMIT) begin
        addr_r <= addr16_s[ADDR_WIDTH-1:0];
        data_r <= data32_s[DATA_WIDTH-1:0];
      end else begin
        addr_r <= addr_r;
        data_r <= data_r;
      end
    end
  end

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_csum_err_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (csum_err_s),
    .count_o (csum_err_cnt_o)
  );

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_timeout_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (timeout_s),
    .count_o (timeout_cnt_o)
  );

  assign byte_ready_o = ready_r;
  assign busy_o       = busy_r;
  assign cmd_valid_o  = valid_r;
  assign cmd_addr_o   = addr_r;
  assign cmd_data_o   = data_r;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder: default instance plus a narrow instance
// with a 3-bit error counter and short timeout for saturation and width mapping.
module tb_cmd_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic [15:0] csum_err_cnt, timeout_cnt;
  logic        busy;

  logic [7:0]  s_byte = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_addr;
  logic [15:0] s_data;
  logic        s_cmd_valid;
  logic [2:0]  s_csum_cnt, s_to_cnt;
  logic        s_busy;

  int vectors = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  int ready_viol = 0;
  logic [15:0] last_addr = 16'h0000, prev_addr = 16'h0000;
  logic [31:0] last_data = 32'h0, prev_data = 32'h0;

  always #5 clk = ~clk;

  cmd_frame_decoder u_dut (
    .clk_i(clk), .rst_i(rst), .byte_i(byte_in), .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready), .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data),
    .cmd_valid_o(cmd_valid), .csum_err_cnt_o(csum_err_cnt),
    .timeout_cnt_o(timeout_cnt), .busy_o(busy)
  );

  cmd_frame_decoder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .SYNC_BYTE(8'hA5),
                      .TIMEOUT_CYCLES(4), .ERR_CNT_WIDTH(3)) u_sat (
    .clk_i(clk), .rst_i(rst), .byte_i(s_byte), .byte_valid_i(s_valid),
    .byte_ready_o(s_ready), .cmd_addr_o(s_addr), .cmd_data_o(s_data),
    .cmd_valid_o(s_cmd_valid), .csum_err_cnt_o(s_csum_cnt),
    .timeout_cnt_o(s_to_cnt), .busy_o(s_busy)
  );

  // Strobe log and ready/valid complementarity monitor for the default instance.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      prev_addr = last_addr; prev_data = last_data;
      last_addr = cmd_addr;  last_data = cmd_data;
    end
    if (byte_ready !== ~cmd_valid) ready_viol = ready_viol + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b; byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL ready_wait: byte_ready=%b required 1", byte_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_byte_sat(input logic [7:0] b);
    int n = 0;
    s_byte = b; s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL sat_ready_wait: s_ready=%b required 1", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0; s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f [8]);
    for (int i = 0; i < 8; i++) send_byte(f[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({byte_ready, cmd_valid, busy} !== 3'b100 || cmd_addr !== 16'h0 || cmd_data !== 32'h0 ||
        csum_err_cnt !== 16'h0 || timeout_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: ready/valid/busy=%b addr=%h data=%h csum=%h to=%h required 100,0,0,0,0",
               {byte_ready, cmd_valid, busy}, cmd_addr, cmd_data, csum_err_cnt, timeout_cnt);
    end
  endtask

  task automatic test_good_frame;
    logic [7:0] f [8] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h70};
    int s0 = strobe_cnt;
    send_frame(f);
    byte_valid = 1'b0;
    vectors++;
    if (cmd_valid !== 1'b1 || cmd_addr !== 16'h0010 || cmd_data !== 32'h00000080) begin
      miscompares++;
      $display("FAIL good_strobe: valid=%b addr=%h data=%h required 1 0010 00000080", cmd_valid, cmd_addr, cmd_data);
    end
    @(negedge clk);
    vectors++;
    if (cmd_valid !== 1'b0 || cmd_addr !== 16'h0010 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL good_after: valid=%b addr=%h busy=%b required 0 0010 0", cmd_valid, cmd_addr, busy);
    end
    idle(2);
    vectors++;
    if (strobe_cnt - s0 !== 1) begin
      miscompares++;
      $display("FAIL good_count: strobes=%0d required 1", strobe_cnt - s0);
    end
  endtask

  task automatic test_bad_checksum;
    logic [7:0] bad [8]  = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h71};
    logic [7:0] good [8] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h70};
    int s0 = strobe_cnt;
    send_frame(bad);
    idle(2);
    vectors++;
    if (csum_err_cnt !== 16'd1 || strobe_cnt - s0 !== 0) begin
      miscompares++;
      $display("FAIL bad_csum: csum_err=%0d strobes=%0d required 1 0", csum_err_cnt, strobe_cnt - s0);
    end
    send_frame(good);
    idle(2);
    vectors++;
    if (strobe_cnt - s0 !== 1 || last_addr !== 16'h0010 || last_data !== 32'h80) begin
      miscompares++;
      $display("FAIL csum_recover: strobes=%0d addr=%h data=%h required 1 0010 00000080",
               strobe_cnt - s0, last_addr, last_data);
    end
  endtask

  task automatic test_garbage;
    logic [7:0] f [8] = '{8'hA5, 8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 8'hC8, 8'hD8};
    int s0 = strobe_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    send_frame(f);
    idle(2);
    vectors++;
    if (strobe_cnt - s0 !== 1 || last_addr !== 16'h0060 || last_data !== 32'h000000C8 || csum_err_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL garbage: strobes=%0d addr=%h data=%h csum=%0d required 1 0060 000000c8 1",
               strobe_cnt - s0, last_addr, last_data, csum_err_cnt);
    end
  endtask

  task automatic test_timeout;
    int s0 = strobe_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h50);
    idle(999);
    vectors++;
    if (busy !== 1'b1 || timeout_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL timeout_early: busy=%b timeout=%0d required 1 0", busy, timeout_cnt);
    end
    idle(1);
    vectors++;
    if (busy !== 1'b0 || timeout_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL timeout_fire: busy=%b timeout=%0d required 0 1", busy, timeout_cnt);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80); send_byte(8'h30);
    idle(2);
    vectors++;
    if (busy !== 1'b0 || strobe_cnt - s0 !== 0) begin
      miscompares++;
      $display("FAIL timeout_late: busy=%b strobes=%0d required 0 0", busy, strobe_cnt - s0);
    end
    // Byte arriving on the would-be expiry cycle keeps the frame alive.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h50);
    idle(999);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80); send_byte(8'h30);
    idle(2);
    vectors++;
    if (timeout_cnt !== 16'd1 || strobe_cnt - s0 !== 1 || last_addr !== 16'h0050 || last_data !== 32'h80) begin
      miscompares++;
      $display("FAIL timeout_edge: timeout=%0d strobes=%0d addr=%h data=%h required 1 1 0050 00000080",
               timeout_cnt, strobe_cnt - s0, last_addr, last_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] f1 [8] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h70};
    logic [7:0] f2 [8] = '{8'hA5, 8'h00, 8'h60, 8'h00, 8'h00, 8'h00, 8'hC8, 8'hD8};
    int s0 = strobe_cnt;
    int v0 = ready_viol;
    send_frame(f1);
    send_frame(f2);
    idle(2);
    vectors++;
    if (strobe_cnt - s0 !== 2 || prev_addr !== 16'h0010 || prev_data !== 32'h80 ||
        last_addr !== 16'h0060 || last_data !== 32'hC8) begin
      miscompares++;
      $display("FAIL b2b_strobes: n=%0d first=%h/%h second=%h/%h required 2 0010/00000080 0060/000000c8",
               strobe_cnt - s0, prev_addr, prev_data, last_addr, last_data);
    end
    vectors++;
    if (ready_viol - v0 !== 0) begin
      miscompares++;
      $display("FAIL b2b_ready: ready/valid overlap cycles=%0d required 0", ready_viol - v0);
    end
  endtask

  task automatic test_mid_frame_reset;
    logic [7:0] f [8] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h70};
    int s0 = strobe_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (strobe_cnt - s0 !== 0 || csum_err_cnt !== 16'd0 || timeout_cnt !== 16'd0 || busy !== 1'b0 ||
        byte_ready !== 1'b1 || cmd_addr !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_mid: strobes=%0d csum=%0d to=%0d busy=%b ready=%b addr=%h required 0 0 0 0 1 0000",
               strobe_cnt - s0, csum_err_cnt, timeout_cnt, busy, byte_ready, cmd_addr);
    end
    send_frame(f);
    idle(2);
    vectors++;
    if (strobe_cnt - s0 !== 1 || last_addr !== 16'h0010 || last_data !== 32'h80) begin
      miscompares++;
      $display("FAIL rst_recover: strobes=%0d addr=%h data=%h required 1 0010 00000080",
               strobe_cnt - s0, last_addr, last_data);
    end
  endtask

  task automatic test_saturation;
    logic [7:0] bad [8]  = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h80, 8'h71};
    logic [7:0] good [8] = '{8'hA5, 8'h12, 8'h34, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hCA};
    for (int k = 0; k < 7; k++)
      for (int i = 0; i < 8; i++) send_byte_sat(bad[i]);
    idle(1);
    vectors++;
    if (s_csum_cnt !== 3'd7) begin
      miscompares++;
      $display("FAIL sat_reach: count=%0d required 7", s_csum_cnt);
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) send_byte_sat(bad[i]);
    idle(1);
    vectors++;
    if (s_csum_cnt !== 3'd7) begin
      miscompares++;
      $display("FAIL sat_hold: count=%0d required 7", s_csum_cnt);
    end
    for (int i = 0; i < 8; i++) send_byte_sat(good[i]);
    s_valid = 1'b0;
    vectors++;
    if (s_cmd_valid !== 1'b1 || s_addr !== 8'h34 || s_data !== 16'hCDEF) begin
      miscompares++;
      $display("FAIL narrow_map: valid=%b addr=%h data=%h required 1 34 cdef", s_cmd_valid, s_addr, s_data);
    end
    send_byte_sat(8'hA5);
    idle(4);
    vectors++;
    if (s_to_cnt !== 3'd1 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_timeout: count=%0d busy=%b required 1 0", s_to_cnt, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_back_to_back();
    test_mid_frame_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
